// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operand, HI/LO move and result bundle between the
// execute stage and the iterative multiply/divide unit.
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, srca, srcb, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, srca, srcb, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 32-bit multiply/divide unit that owns the
// architectural HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// One operation takes 32 CALC cycles plus one FIX cycle for sign correction.
// Optional feature macro: MDU_FLUSH_EN adds a `flush` input that aborts an
// in-flight operation without touching HI/LO.
module mul_div_unit (
    input  logic           sys_clk,
    input  logic           sys_rst,
`ifdef MDU_FLUSH_EN
    input  logic           flush,
`endif
    mul_div_unit_if.slave  mdu
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Two's-complement negation helpers for sign correction.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    // Magnitude of a signed operand; unsigned operands pass through unchanged.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? neg32(v) : v;
    endfunction

    state_t      state_r, state_nx_s;
    logic        busy_r, done_r;
    logic [31:0] hi_r, lo_r;
    logic [63:0] p_r;        // mult: {accum, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] d_r;        // mult: multiplicand magnitude; div: divisor magnitude
    logic [5:0]  count_r;
    logic        is_div_r, neg_p_r, neg_r_r;

    logic        flush_s, accept_s, step_s, fix_s, mt_en_s;
    logic        signed_s, div0_s, sign_diff_s;
    logic [31:0] a_abs_s, b_abs_s;
    logic [32:0] mult_sum_s;
    logic [33:0] div_diff_s;
    logic [63:0] step_nx_s, prod_fix_s;
    logic [31:0] quo_fix_s, rem_fix_s, res_hi_s, res_lo_s;

`ifdef MDU_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        step_s     = 1'b0;
        fix_s      = 1'b0;
        mt_en_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (mdu.start && !flush_s) begin
                    accept_s   = 1'b1;
                    state_nx_s = CALC;
                end else begin
                    mt_en_s    = 1'b1;
                end
            end
            CALC: begin
                if (flush_s) begin
                    state_nx_s = IDLE;
                end else begin
                    step_s = 1'b1;
                    if (count_r == 6'd31) begin
                        state_nx_s = FIX;
                    end else begin
                        state_nx_s = CALC;
                    end
                end
            end
            FIX: begin
                state_nx_s = IDLE;
                if (flush_s) begin
                    fix_s = 1'b0;
                end else begin
                    fix_s = 1'b1;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Operand conditioning and one radix-2 step of multiply or restoring divide.
    always_comb begin
        signed_s    = ~mdu.op[0];
        div0_s      = (mdu.srcb == 32'd0);
        sign_diff_s = signed_s & (mdu.srca[31] ^ mdu.srcb[31]);
        a_abs_s     = abs32(mdu.srca, signed_s);
        b_abs_s     = abs32(mdu.srcb, signed_s);
        mult_sum_s  = {1'b0, p_r[63:32]} + {1'b0, d_r};
        div_diff_s  = {1'b0, p_r[63:31]} - {2'b00, d_r};
        if (is_div_r) begin
            if (div_diff_s[33]) begin
                step_nx_s = {p_r[62:31], p_r[30:0], 1'b0};
            end else begin
                step_nx_s = {div_diff_s[31:0], p_r[30:0], 1'b1};
            end
        end else begin
            if (p_r[0]) begin
                step_nx_s = {mult_sum_s, p_r[31:1]};
            end else begin
                step_nx_s = {1'b0, p_r[63:1]};
            end
        end
    end

    // Sign correction of the finished magnitude result and HI/LO selection.
    always_comb begin
        prod_fix_s = neg_p_r ? neg64(p_r) : p_r;
        quo_fix_s  = neg_p_r ? neg32(p_r[31:0]) : p_r[31:0];
        rem_fix_s  = neg_r_r ? neg32(p_r[63:32]) : p_r[63:32];
        if (is_div_r) begin
            res_hi_s = rem_fix_s;
            res_lo_s = quo_fix_s;
        end else begin
            res_hi_s = prod_fix_s[63:32];
            res_lo_s = prod_fix_s[31:0];
        end
    end

    // Datapath: latch operands on accept, iterate while in CALC.
    // A zero divisor falls out of the restoring loop as quotient all-ones and
    // remainder = |dividend|; keeping the quotient unnegated and giving the
    // remainder the dividend's sign reproduces the raw srca in HI.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            p_r      <= 64'd0;
            d_r      <= 32'd0;
            count_r  <= 6'd0;
            is_div_r <= 1'b0;
            neg_p_r  <= 1'b0;
            neg_r_r  <= 1'b0;
        end else if (accept_s) begin
            count_r  <= 6'd0;
            is_div_r <= mdu.op[1];
            if (mdu.op[1]) begin
                d_r     <= b_abs_s;
                p_r     <= {32'd0, a_abs_s};
                neg_p_r <= sign_diff_s & ~div0_s;
                neg_r_r <= signed_s & mdu.srca[31];
            end else begin
                d_r     <= a_abs_s;
                p_r     <= {32'd0, b_abs_s};
                neg_p_r <= sign_diff_s;
                neg_r_r <= 1'b0;
            end
        end else if (step_s) begin
            p_r     <= step_nx_s;
            count_r <= count_r + 6'd1;
        end
    end

    // Architectural HI/LO: result load from FIX, MTHI/MTLO only when idle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (fix_s) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end else if (mt_en_s) begin
            if (mdu.hi_we) begin
                hi_r <= mdu.wdata;
            end
            if (mdu.lo_we) begin
                lo_r <= mdu.wdata;
            end
        end
    end

    // Registered status: busy follows the next state, done marks the FIX load.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != IDLE);
            done_r <= fix_s;
        end
    end

    assign mdu.busy = busy_r;
    assign mdu.done = done_r;
    assign mdu.hi   = hi_r;
    assign mdu.lo   = lo_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit with hand-computed
// HI/LO results, latency, MTHI/MTLO, busy-time blocking and reset abort.
module tb_mul_div_unit;

    logic sys_clk;
    logic sys_rst;
`ifdef MDU_FLUSH_EN
    logic flush;
`endif
    int   n_cmp;
    int   n_err;

    mul_div_unit_if mdu_bus ();

    mul_div_unit dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
`ifdef MDU_FLUSH_EN
        .flush   (flush),
`endif
        .mdu     (mdu_bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Single comparison point: counts and reports each check.
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for done with a bound, check latency and result.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  n;
        bit  seen;
        @(negedge sys_clk);
        mdu_bus.start = 1'b1;
        mdu_bus.op    = o;
        mdu_bus.srca  = a;
        mdu_bus.srcb  = b;
        @(posedge sys_clk);
        #1;
        mdu_bus.start = 1'b0;
        mdu_bus.srca  = 32'h5A5A_0F0F;
        mdu_bus.srcb  = 32'hC3C3_F0F0;
        check_val({tag, " busy"}, {63'd0, mdu_bus.busy}, 64'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge sys_clk);
            #1;
            n++;
            if (mdu_bus.done) seen = 1'b1;
        end
        check_val({tag, " latency"}, 64'(n), 64'd33);
        check_val({tag, " hi"}, {32'd0, mdu_bus.hi}, {32'd0, exp_hi});
        check_val({tag, " lo"}, {32'd0, mdu_bus.lo}, {32'd0, exp_lo});
        check_val({tag, " busy_at_done"}, {63'd0, mdu_bus.busy}, 64'd0);
        @(posedge sys_clk);
        #1;
        check_val({tag, " done_one_cycle"}, {63'd0, mdu_bus.done}, 64'd0);
    endtask

    initial begin
        int dones;
        n_cmp = 0;
        n_err = 0;
        sys_rst = 1'b1;
        mdu_bus.start = 1'b0;
        mdu_bus.op    = 2'b00;
        mdu_bus.srca  = 32'd0;
        mdu_bus.srcb  = 32'd0;
        mdu_bus.hi_we = 1'b0;
        mdu_bus.lo_we = 1'b0;
        mdu_bus.wdata = 32'd0;
`ifdef MDU_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge sys_clk);
        #1;
        check_val("rst busy", {63'd0, mdu_bus.busy}, 64'd0);
        check_val("rst done", {63'd0, mdu_bus.done}, 64'd0);
        check_val("rst hi", {32'd0, mdu_bus.hi}, 64'd0);
        check_val("rst lo", {32'd0, mdu_bus.lo}, 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        run_op("mult_m1x2",   2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_m1x2",  2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_m3x5",   2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_m7d2",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2",    2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_100d7",  2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_by0",    2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_neg_by0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // MTHI alone, then MTHI+MTLO together.
        @(negedge sys_clk);
        mdu_bus.hi_we = 1'b1;
        mdu_bus.wdata = 32'hA5A5_A5A5;
        @(posedge sys_clk);
        #1;
        mdu_bus.hi_we = 1'b0;
        check_val("mthi hi", {32'd0, mdu_bus.hi}, {32'd0, 32'hA5A5_A5A5});
        check_val("mthi lo_kept", {32'd0, mdu_bus.lo}, {32'd0, 32'h8000_0000});
        @(negedge sys_clk);
        mdu_bus.hi_we = 1'b1;
        mdu_bus.lo_we = 1'b1;
        mdu_bus.wdata = 32'h1357_9BDF;
        @(posedge sys_clk);
        #1;
        mdu_bus.hi_we = 1'b0;
        mdu_bus.lo_we = 1'b0;
        check_val("mthi_mtlo hi", {32'd0, mdu_bus.hi}, {32'd0, 32'h1357_9BDF});
        check_val("mthi_mtlo lo", {32'd0, mdu_bus.lo}, {32'd0, 32'h1357_9BDF});

        // Start with MTLO in the same cycle: start wins, write dropped.
        @(negedge sys_clk);
        mdu_bus.start = 1'b1;
        mdu_bus.op    = 2'b01;
        mdu_bus.srca  = 32'd3;
        mdu_bus.srcb  = 32'd4;
        mdu_bus.lo_we = 1'b1;
        mdu_bus.wdata = 32'hDEAD_BEEF;
        @(posedge sys_clk);
        #1;
        mdu_bus.start = 1'b0;
        mdu_bus.lo_we = 1'b0;
        check_val("start_wins lo", {32'd0, mdu_bus.lo}, {32'd0, 32'h1357_9BDF});
        // Second start and MTLO while busy must be ignored.
        repeat (5) @(posedge sys_clk);
        #1;
        mdu_bus.start = 1'b1;
        mdu_bus.op    = 2'b10;
        mdu_bus.srca  = 32'd99;
        mdu_bus.srcb  = 32'd5;
        mdu_bus.lo_we = 1'b1;
        mdu_bus.hi_we = 1'b1;
        mdu_bus.wdata = 32'hDEAD_BEEF;
        @(posedge sys_clk);
        #1;
        mdu_bus.start = 1'b0;
        mdu_bus.lo_we = 1'b0;
        mdu_bus.hi_we = 1'b0;
        dones = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge sys_clk);
            #1;
            if (mdu_bus.done) dones++;
        end
        check_val("busy_ignore dones", 64'(dones), 64'd1);
        check_val("busy_ignore hi", {32'd0, mdu_bus.hi}, 64'd0);
        check_val("busy_ignore lo", {32'd0, mdu_bus.lo}, 64'd12);

        // Reset during CALC aborts and clears immediately.
        @(negedge sys_clk);
        mdu_bus.start = 1'b1;
        mdu_bus.op    = 2'b00;
        mdu_bus.srca  = 32'd6;
        mdu_bus.srcb  = 32'd7;
        @(posedge sys_clk);
        #1;
        mdu_bus.start = 1'b0;
        repeat (10) @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        check_val("midrst busy", {63'd0, mdu_bus.busy}, 64'd0);
        check_val("midrst done", {63'd0, mdu_bus.done}, 64'd0);
        check_val("midrst hi", {32'd0, mdu_bus.hi}, 64'd0);
        check_val("midrst lo", {32'd0, mdu_bus.lo}, 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        run_op("after_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

`ifdef MDU_FLUSH_EN
        // Flush at CALC cycle 5: abort, HI/LO unchanged, no done.
        @(negedge sys_clk);
        mdu_bus.start = 1'b1;
        mdu_bus.op    = 2'b01;
        mdu_bus.srca  = 32'd9;
        mdu_bus.srcb  = 32'd9;
        @(posedge sys_clk);
        #1;
        mdu_bus.start = 1'b0;
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        flush = 1'b1;
        @(posedge sys_clk);
        #1;
        flush = 1'b0;
        check_val("flush busy", {63'd0, mdu_bus.busy}, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge sys_clk);
            #1;
            if (mdu_bus.done) dones++;
        end
        check_val("flush dones", 64'(dones), 64'd0);
        check_val("flush hi", {32'd0, mdu_bus.hi}, 64'd0);
        check_val("flush lo", {32'd0, mdu_bus.lo}, 64'd42);
        // Flush together with start in IDLE: start ignored.
        @(negedge sys_clk);
        mdu_bus.start = 1'b1;
        flush = 1'b1;
        @(posedge sys_clk);
        #1;
        mdu_bus.start = 1'b0;
        flush = 1'b0;
        check_val("flush_start busy", {63'd0, mdu_bus.busy}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
